// File: rtl/padctl_strap_mux.sv
// Pad controller: GPIO o/oe pass-through, input sync, strap latch FSM, JTAG/SPI debug mux.
// Optional GPIO glitch filter is built when PADCTL_GLITCH_FILT_EN is defined.
module padctl_strap_mux #(
  parameter int unsigned NUM_GPIO    = 16,
  parameter int unsigned STRAP_DELAY = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_GPIO-1:0] gpio_d2p,
  input  logic [NUM_GPIO-1:0] gpio_en_d2p,
  output logic [NUM_GPIO-1:0] gpio_p2d,
  input  logic [NUM_GPIO-1:0] pad_gpio_i,
  output logic [NUM_GPIO-1:0] pad_gpio_o,
  output logic [NUM_GPIO-1:0] pad_gpio_oe,
  input  logic [1:0]          pad_strap_i,
  output logic [1:0]          strap_o,
  output logic                strap_valid_o,
  input  logic [4:0]          pad_dbg_i,
  output logic                pad_dbg_o,
  output logic                pad_dbg_oe,
  output logic                spi_sck_o,
  output logic                spi_csb_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  input  logic                spi_miso_en_i,
  output logic                jtag_tck_o,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  output logic                jtag_trst_no,
  output logic                jtag_srst_no,
  input  logic                jtag_tdo_i
);

  localparam int unsigned SW = NUM_GPIO + 2;
  localparam int unsigned CW =
    (STRAP_DELAY > 1) ? $clog2(STRAP_DELAY) : 1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SAMPLE,
    ST_LOCKED
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [1:0]                     strap_q, strap_d;
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [NUM_GPIO-1:0]            gpio_sync;
  logic [1:0]                     strap_sync;
  logic                           locked;

  assign pad_gpio_o  = gpio_d2p;
  assign pad_gpio_oe = gpio_en_d2p;

  // Straps share the GPIO synchroniser chain but bypass the filter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {pad_strap_i, pad_gpio_i};
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign {strap_sync, gpio_sync} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      strap_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strap_q <= strap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strap_d = strap_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == CW'(STRAP_DELAY - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        strap_d = strap_sync;
        state_d = ST_LOCKED;
      end
      ST_LOCKED: ;
      default: state_d = ST_WAIT;
    endcase
  end

  assign locked        = (state_q == ST_LOCKED);
  assign strap_o       = strap_q;
  assign strap_valid_o = locked;

  always_comb begin
    spi_sck_o    = 1'b0;
    spi_mosi_o   = 1'b0;
    spi_csb_o    = 1'b1;
    jtag_tck_o   = 1'b0;
    jtag_tms_o   = 1'b0;
    jtag_tdi_o   = 1'b0;
    jtag_trst_no = 1'b0;
    jtag_srst_no = 1'b1;
    pad_dbg_o    = 1'b0;
    pad_dbg_oe   = 1'b0;
    unique case (1'b1)
      !locked: ;
      locked && strap_q[0]: begin
        jtag_tck_o   = pad_dbg_i[0];
        jtag_tdi_o   = pad_dbg_i[1];
        jtag_tms_o   = pad_dbg_i[2];
        jtag_trst_no = pad_dbg_i[3];
        jtag_srst_no = pad_dbg_i[4];
        pad_dbg_o    = jtag_tdo_i;
        pad_dbg_oe   = 1'b1;
      end
      locked && !strap_q[0]: begin
        spi_sck_o    = pad_dbg_i[0];
        spi_mosi_o   = pad_dbg_i[1];
        spi_csb_o    = pad_dbg_i[2];
        jtag_trst_no = 1'b1;
        pad_dbg_o    = spi_miso_i;
        pad_dbg_oe   = spi_miso_en_i;
      end
      default: ;
    endcase
  end

`ifdef PADCTL_GLITCH_FILT_EN
  localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

  logic [NUM_GPIO-1:0]         prev_q;
  logic [NUM_GPIO-1:0]         filt_q, filt_d;
  logic [NUM_GPIO-1:0][FW-1:0] fcnt_q, fcnt_d;

  // fcnt counts consecutive equal sample pairs; FILT_CYCLES-1 pairs = FILT_CYCLES samples
  always_comb begin
    fcnt_d = fcnt_q;
    filt_d = filt_q;
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (gpio_sync[i] != prev_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] != FW'(FILT_CYCLES)) begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
      if (fcnt_d[i] >= FW'(FILT_CYCLES - 1)) begin
        filt_d[i] = gpio_sync[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      fcnt_q <= '0;
      filt_q <= '0;
    end else begin
      prev_q <= gpio_sync;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign gpio_p2d = filt_q;
`else
  assign gpio_p2d = gpio_sync;
`endif

endmodule

// File: doc/padctl_strap_mux.md
Name: padctl_strap_mux

Overview:
Parametrised successor pad controller for the earlgrey top. It owns NUM_GPIO bidirectional GPIO pads, a 5-input/1-output debug port, and two strap pins. Straps are sampled once after reset by a small FSM and then locked. The locked strap statically selects JTAG or SPI-device on the debug pins. GPIO inputs are resynchronised, and an optional glitch filter can be compiled in. Tristate buffers live in the top-level pad ring; this block drives only o/oe pairs.

Parameters:
NUM_GPIO, 16, number of GPIO pads (1..32)
STRAP_DELAY, 8, clk_i cycles after reset deassertion before straps are sampled (>=2)
SYNC_STAGES, 2, flop stages on each GPIO/strap input (2..3)
FILT_CYCLES, 4, stable cycles required by the glitch filter (only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  async active-low reset
gpio_d2p  in  NUM_GPIO  GPIO output data from core
gpio_en_d2p  in  NUM_GPIO  GPIO output enable from core
gpio_p2d  out  NUM_GPIO  synchronised (optionally filtered) GPIO input to core
pad_gpio_i  in  NUM_GPIO  GPIO pad input
pad_gpio_o  out  NUM_GPIO  GPIO pad output
pad_gpio_oe  out  NUM_GPIO  GPIO pad output enable
pad_strap_i  in  2  [0]=jtag_spi_n, [1]=boot_strap
strap_o  out  2  latched straps
strap_valid_o  out  1  straps latched and debug mux enabled
pad_dbg_i  in  5  [0]=sck/tck, [1]=mosi/tdi, [2]=csb/tms, [3]=trst_n, [4]=srst_n
pad_dbg_o  out  1  miso/tdo pad output
pad_dbg_oe  out  1  miso/tdo pad output enable
spi_sck_o, spi_csb_o, spi_mosi_o  out  1 each  to spi_device
spi_miso_i, spi_miso_en_i  in  1 each  from spi_device
jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, jtag_srst_no  out  1 each  to debug module
jtag_tdo_i  in  1  from debug module

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- GPIO out path is combinational: pad_gpio_o = gpio_d2p; pad_gpio_oe = gpio_en_d2p.
- GPIO in path: SYNC_STAGES flops per bit. Latency is SYNC_STAGES cycles from the pad to gpio_p2d. Sync flops reset to 0.
- Strap FSM states:
  - WAIT: counter runs 0..STRAP_DELAY-1; the strap inputs pass through the same synchroniser.
  - SAMPLE: one cycle. Captures the synchronised straps into strap_o.
  - LOCKED: terminal. Leaves only on rst_ni.
  - Transitions: WAIT -> SAMPLE when the counter reaches STRAP_DELAY-1. SAMPLE -> LOCKED unconditionally.
- strap_valid_o = 1 in LOCKED only. It rises STRAP_DELAY+1 cycles after the first clk_i edge following reset release.
- Changes on pad_strap_i after SAMPLE are ignored.
- Reset values: strap_o=2'b00, strap_valid_o=0, state=WAIT, counter=0, gpio_p2d=0.
- Debug mux while strap_valid_o=0 (both interfaces idle):
  - spi_csb_o=1, spi_sck_o=0, spi_mosi_o=0.
  - jtag_tck_o=0, jtag_tms_o=0, jtag_tdi_o=0.
  - jtag_trst_no=0 (TAP held in reset), jtag_srst_no=1.
  - pad_dbg_oe=0, pad_dbg_o=0.
- Debug mux in LOCKED with strap_o[0]=1 (JTAG):
  - jtag_tck_o=pad_dbg_i[0], tdi=[1], tms=[2], trst_no=[3], srst_no=[4].
  - pad_dbg_o=jtag_tdo_i, pad_dbg_oe=1.
  - SPI outputs held at the idle values (csb=1).
- Debug mux in LOCKED with strap_o[0]=0 (SPI):
  - spi_sck_o=[0], spi_mosi_o=[1], spi_csb_o=[2].
  - pad_dbg_o=spi_miso_i, pad_dbg_oe=spi_miso_en_i.
  - JTAG outputs: tck=0, tms=0, tdi=0, trst_no=1, srst_no=1.
- Debug data paths are combinational and unsynchronised; tck and sck are clocks. The select is static after LOCKED, so no glitch-free mux is required.
- Reset mid-operation: asserting rst_ni in any state immediately returns every output to its reset or idle value, combinationally via the async clear. This includes dropping pad_dbg_oe to 0.

Optional Feature:
Macro: PADCTL_GLITCH_FILT_EN
- Defined:
  - Each synchronised GPIO bit feeds a filter with a saturating counter of width clog2(FILT_CYCLES+1).
  - The counter clears whenever the input differs from the previous sample.
  - gpio_p2d[i] takes the new value only after the input has been stable for FILT_CYCLES consecutive cycles.
  - Total latency = SYNC_STAGES+FILT_CYCLES cycles. Pulses shorter than FILT_CYCLES cycles are suppressed.
  - Counters and filter outputs reset to 0.
- Undefined: no filter logic; gpio_p2d is the synchroniser output directly.
- Straps are never filtered in either build.

Test Plan:
- Reset release with pad_strap_i=2'b11 held -> strap_valid_o=1 at cycle STRAP_DELAY+1 (9 by default), strap_o=2'b11, JTAG routed, pad_dbg_oe=1, pad_dbg_o follows jtag_tdo_i.
- pad_strap_i=2'b00 at sample, then toggled to 2'b11 -> strap_o remains 2'b00; SPI routed; pad_dbg_i[2]=0 gives spi_csb_o=0; spi_miso_en_i=0 gives pad_dbg_oe=0.
- Before lock, drive pad_dbg_i=5'b11111 -> spi_csb_o=1, jtag_trst_no=0, jtag_tck_o=0, pad_dbg_oe=0.
- NUM_GPIO=32: pad_gpio_i=32'hA5A5_0F0F -> gpio_p2d equals it after exactly 2 cycles; gpio_en_d2p=32'hFFFF_0000, gpio_d2p=32'h1234_5678 -> pad_gpio_oe/pad_gpio_o match same cycle.
- With PADCTL_GLITCH_FILT_EN: 3-cycle pulse on pad_gpio_i[0] -> gpio_p2d[0] stays 0; 4-cycle pulse -> rises 6 cycles after the input edge.
- Assert rst_ni in LOCKED (JTAG) mid-transfer -> pad_dbg_oe=0 and strap_valid_o=0 immediately; after release the straps are resampled with fresh values.
